// File: rtl/cpu_mem_sequencer_if.sv
//------------------------------------------------------------------------------
// cpu_mem_sequencer_if
//
// Purpose:
//   Valid/ready request channel between the CPU memory sequencer and the
//   external memory fabric (SDRAM/BRAM arbiter). One request is outstanding
//   at most; a transfer occurs on any clock where ext_valid and ext_ready
//   are both high.
//
// Signals:
//   ext_valid  sequencer -> fabric  request valid
//   ext_write  sequencer -> fabric  request is a write
//   ext_addr   sequencer -> fabric  request address (ADDR_WIDTH)
//   ext_wdata  sequencer -> fabric  request write data (DATA_WIDTH)
//   ext_ready  fabric -> sequencer  fabric accepts/completes the request
//   ext_rdata  fabric -> sequencer  read data, valid while ext_ready=1 on a read
//
// Modports:
//   master  the sequencer side
//   slave   the fabric side
//------------------------------------------------------------------------------
interface cpu_mem_sequencer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) ();

    logic                  ext_valid;
    logic                  ext_write;
    logic [ADDR_WIDTH-1:0] ext_addr;
    logic [DATA_WIDTH-1:0] ext_wdata;
    logic                  ext_ready;
    logic [DATA_WIDTH-1:0] ext_rdata;

    modport master (
        output ext_valid,
        output ext_write,
        output ext_addr,
        output ext_wdata,
        input  ext_ready,
        input  ext_rdata
    );

    modport slave (
        input  ext_valid,
        input  ext_write,
        input  ext_addr,
        input  ext_wdata,
        output ext_ready,
        output ext_rdata
    );

endinterface

// File: rtl/cpu_mem_sequencer.sv
//------------------------------------------------------------------------------
// cpu_mem_sequencer
//
// Purpose:
//   Generates the 2-bit T-cycle phase (T0..T3) that paces the microcoded
//   control unit and turns its per-M-cycle memory request into a single
//   valid/ready transaction on the external memory fabric. The phase is
//   frozen at T2 until the fabric completes, so the control unit only moves
//   on once read data is valid. Read data is held in mem_data_in for the
//   control unit's dispatch and the datapath.
//
// Parameters:
//   ADDR_WIDTH      CPU address width
//   DATA_WIDTH      CPU data width
//   TIMEOUT_CYCLES  clocks spent waiting at T2 before a forced completion
//                   (only meaningful with CPU_MEM_SEQ_TIMEOUT_EN)
//
// Ports:
//   clk          system clock
//   reset_n      synchronous, active-low reset
//   clk_en       CPU clock enable; the phase advances only when high
//   mem_enable   access requested this M-cycle (sampled at T0 only)
//   mem_write    access is a write (sampled at T0 only)
//   cpu_addr     address from datapath (sampled at T0 only)
//   cpu_wdata    write data from datapath (sampled at T0 only)
//   t_cycle      current T-cycle phase, 0..3
//   mem_data_in  last read data
//   cpu_stall    high while the phase is held at T2 awaiting the fabric
//   ext          fabric request channel (master side)
//   bus_error    sticky timeout flag (only with CPU_MEM_SEQ_TIMEOUT_EN)
//
// Build option:
//   CPU_MEM_SEQ_TIMEOUT_EN  when defined, a wait counter bounds the stall at
//                           T2; on expiry the access completes with open-bus
//                           read data (all ones) and bus_error is set.
//------------------------------------------------------------------------------
module cpu_mem_sequencer #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clk_en,
    input  logic                  mem_enable,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [1:0]            t_cycle,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  cpu_stall,
    cpu_mem_sequencer_if.master   ext
`ifdef CPU_MEM_SEQ_TIMEOUT_EN
    ,
    output logic                  bus_error
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    state_t                state;
    logic [1:0]            phase;
    logic                  advance;

    logic                  valid_q;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

`ifdef CPU_MEM_SEQ_TIMEOUT_EN
    // Counter is at least 8 bits wide, wider only if the limit needs it.
    localparam int WAIT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                            $clog2(TIMEOUT_CYCLES + 1) : 8;
    // Completion happens on the clock that would bring the count to the
    // limit, so the stall lasts exactly TIMEOUT_CYCLES clocks.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              bus_error_q;
`else
    // Parameter kept so overrides stay valid whichever way the block is built.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // The stall is decoded from registered state so the control unit sees the
    // hold in the same cycle the phase reaches T2 with the access outstanding.
    assign cpu_stall = (phase == T2) && (state == REQ);
    assign advance   = clk_en && !cpu_stall;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            phase       <= T0;
            valid_q     <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
`ifdef CPU_MEM_SEQ_TIMEOUT_EN
            wait_cnt    <= '0;
            bus_error_q <= 1'b0;
`endif
        end else begin
            if (advance) begin
                phase <= phase + 2'd1;
            end

            unique case (state)
                IDLE: begin
                    // Request sampled only on the T0 -> T1 advance.
                    if (advance && (phase == T0) && mem_enable) begin
                        valid_q  <= 1'b1;
                        write_q  <= mem_write;
                        addr_q   <= cpu_addr;
                        wdata_q  <= cpu_wdata;
                        state    <= REQ;
`ifdef CPU_MEM_SEQ_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end

                REQ: begin
                    // Handshake is independent of clk_en so a transfer may
                    // complete while the phase is frozen.
                    if (ext.ext_ready) begin
                        valid_q <= 1'b0;
                        if (!write_q) begin
                            rdata_q <= ext.ext_rdata;
                        end
                        state <= DONE;
                    end
`ifdef CPU_MEM_SEQ_TIMEOUT_EN
                    else if (phase == T2) begin
                        if (wait_cnt >= WAIT_LAST) begin
                            valid_q     <= 1'b0;
                            if (!write_q) begin
                                rdata_q <= '1;
                            end
                            bus_error_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
`endif
                end

                DONE: begin
                    if (advance && (phase == T3)) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign t_cycle       = phase;
    assign mem_data_in   = rdata_q;
    assign ext.ext_valid = valid_q;
    assign ext.ext_write = write_q;
    assign ext.ext_addr  = addr_q;
    assign ext.ext_wdata = wdata_q;

`ifdef CPU_MEM_SEQ_TIMEOUT_EN
    assign bus_error = bus_error_q;
`endif

endmodule
